ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

AHB-lite slave that converts single AHB-lite transfers into APB4 transfers for the peripheral subsystem. It sits behind the bus-0 AHB-lite fabric as the slave selected for page 0x40 (HSEL_SS0) and drives the APB peripheral bus. It decodes up to 16 APB slots and inserts AHB wait states until the APB transfer completes. It returns APB slave errors, undecoded slots and APB timeouts as a two-cycle AHB ERROR response.

## Interface
- NSLV, 16: number of APB slots (1..16); sets PSEL width.
- SLOT_LSB, 16: lowest HADDR bit of the 4-bit slot index HADDR[SLOT_LSB+3:SLOT_LSB].
- PADDR_W, 16: APB address width; PADDR = captured HADDR[PADDR_W-1:0].
- TIMEOUT, 255: maximum ACCESS cycles with PREADY low before abort (1..255).
- HCLK  in  1  single clock; the APB side runs on HCLK.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the fabric.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means valid.
- HWRITE  in  1  write, when high.
- HSIZE  in  3  transfer size 0/1/2 (byte/half/word).
- HREADY  in  1  bus-level ready; a transfer is sampled only when it is high.
- HWDATA  in  32  write data, valid during the data phase.
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  registered read data.
- HRESP  out  1  1 = ERROR.
- PADDR  out  PADDR_W  APB address.
- PSEL  out  NSLV  one-hot slot select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  byte strobes; always 0 on reads.
- PRDATA  in  32  muxed APB read data.
- PREADY  in  1  muxed APB ready.
- PSLVERR  in  1  muxed APB error.

## Operation
- Valid transfer is HSEL & HTRANS[1] & HREADY, sampled at a rising edge while in IDLE or ERR2.
- On a valid transfer the block captures HADDR, HWRITE and HSIZE.
- PSTRB from HSIZE/HADDR[1:0]: byte gives 1<<addr[1:0]; half gives 4'b0011 or 4'b1100 by addr[1]; word gives 4'b1111.
- States and transitions:
  - IDLE: HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0. A valid transfer goes to ERR1 if the slot index ≥ NSLV. Otherwise a write goes to WDATA and a read goes to SETUP.
  - WDATA: HREADYOUT=0. Registers HWDATA into PWDATA, then goes to SETUP.
  - SETUP: PSEL[slot]=1, PENABLE=0, HREADYOUT=0. Clears the timeout counter, then goes to ACCESS.
  - ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=0.
    - PREADY=1 with PSLVERR=0 goes to IDLE; a read registers PRDATA into HRDATA.
    - PREADY=1 with PSLVERR=1 goes to ERR1; HRDATA is unchanged.
    - PREADY=0 increments the 8-bit counter; when the counter reaches TIMEOUT-1 the state goes to ERR1 and APB is dropped without completion.
  - ERR1: HRESP=1, HREADYOUT=0, PSEL=0. Goes to ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Samples the address phase as IDLE does; goes to IDLE if nothing is sampled.
- Non-valid transfers (IDLE/BUSY, or HSEL=0) get a zero-wait OKAY response.
- PADDR, PWRITE and PSTRB hold their last values outside SETUP/ACCESS.
- HRDATA holds its last completed read value.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0; state is IDLE; counter is 0.
- Reset asserted mid-transfer drops PSEL and PENABLE immediately (asynchronous), with no APB completion.
- Address phase at cycle T. A read with PREADY=1 in its first ACCESS cycle: SETUP at T+1, ACCESS at T+2, HREADYOUT=1 with HRDATA valid at T+3. That is 2 wait states.
- A write with immediate PREADY: WDATA at T+1, SETUP at T+2, ACCESS at T+3, OKAY at T+4. That is 3 wait states.
- Each PREADY-low ACCESS cycle adds one wait state.
- Back-to-back transfers: the next address phase is sampled in the completion cycle (IDLE or ERR2), so there is no idle gap.
- PSEL, PADDR, PWRITE, PWDATA and PSTRB are stable from SETUP through the final ACCESS cycle.

## Test plan
- Word write to 0x40020010 with data 0xA5A5_1234 and PREADY=1: PSEL=16'h0004, PADDR=0x0010, PSTRB=4'hF, PWDATA=0xA5A5_1234; OKAY with 3 wait states.
- Byte read at 0x40010003 with PRDATA=0xCAFEF00D and PREADY low for 3 ACCESS cycles: PSTRB=0; 5 wait states; HRDATA=0xCAFEF00D.
- Write with PSLVERR=1: ERR1 gives HRESP=1/HREADYOUT=0, ERR2 gives HRESP=1/HREADYOUT=1, then OKAY idle.
- NSLV=4 with an access to slot 5: no PSEL asserted; immediate two-cycle ERROR.
- TIMEOUT=8 with PREADY held 0: exactly 8 ACCESS cycles, then PSEL=0 and an ERROR response.
- Read then write back-to-back, with HRESETn pulsed low during ACCESS of a third transfer: the first two complete correctly; all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// AHB-lite slave that turns single AHB transfers into APB4 transfers on up to 16 slots.
// Wait states are held until APB completes; slave errors, bad slots and timeouts return ERROR.
module ahb_apb_bridge #(
   parameter int unsigned NSLV     = 16,
   parameter int unsigned SLOT_LSB = 16,
   parameter int unsigned PADDR_W  = 16,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [31:0]        HADDR,
   input  logic [1:0]         HTRANS,
   input  logic               HWRITE,
   input  logic [2:0]         HSIZE,
   input  logic               HREADY,
   input  logic [31:0]        HWDATA,
   output logic               HREADYOUT,
   output logic [31:0]        HRDATA,
   output logic               HRESP,
   output logic [PADDR_W-1:0] PADDR,
   output logic [NSLV-1:0]    PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [31:0]        PWDATA,
   output logic [3:0]         PSTRB,
   input  logic [31:0]        PRDATA,
   input  logic               PREADY,
   input  logic               PSLVERR
);

   localparam int unsigned SLOT_W = 4;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
   } state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [PADDR_W-1:0]  addr_q, addr_d;
   logic                write_q, write_d;
   logic [2:0]          size_q, size_d;
   logic [PADDR_W-1:0]  paddr_d;
   logic                pwrite_d;
   logic [3:0]          pstrb_d;
   logic [31:0]         pwdata_d;
   logic [31:0]         hrdata_d;
   logic [NSLV-1:0]     psel_d;
   logic                penable_d;
   logic                hreadyout_d;
   logic                hresp_d;
   logic                valid;
   logic                unused_bits;

   assign valid       = HSEL & HTRANS[1] & HREADY;
   assign unused_bits = ^{HADDR, HTRANS[0]};

   // Byte lanes for a write of the given size at the given low address bits.
   function automatic logic [3:0] strb_f(input logic [2:0] size, input logic [1:0] a);
      case (size)
         3'd0:    strb_f = 4'b0001 << a;
         3'd1:    strb_f = a[1] ? 4'b1100 : 4'b0011;
         default: strb_f = 4'b1111;
      endcase
   endfunction

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      slot_d   = slot_q;
      addr_d   = addr_q;
      write_d  = write_q;
      size_d   = size_q;
      paddr_d  = PADDR;
      pwrite_d = PWRITE;
      pstrb_d  = PSTRB;
      pwdata_d = PWDATA;
      hrdata_d = HRDATA;
      psel_d   = '0;

      case (state)
         S_IDLE, S_ERR2: begin
            state_d = S_IDLE;
            if (valid) begin
               slot_d  = HADDR[SLOT_LSB +: SLOT_W];
               addr_d  = HADDR[PADDR_W-1:0];
               write_d = HWRITE;
               size_d  = HSIZE;
               if (32'(slot_d) >= NSLV) state_d = S_ERR1;
               else if (HWRITE)         state_d = S_WDATA;
               else                     state_d = S_SETUP;
            end
         end
         S_WDATA: begin
            pwdata_d = HWDATA;
            state_d  = S_SETUP;
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR) begin
                  state_d = S_ERR1;
               end else begin
                  state_d = S_IDLE;
                  if (!write_q) hrdata_d = PRDATA;
               end
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR1;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         S_ERR1:  state_d = S_ERR2;
         default: state_d = S_IDLE;
      endcase

      // APB address-phase signals only change on entry to SETUP.
      if (state_d == S_SETUP) begin
         paddr_d  = addr_d;
         pwrite_d = write_d;
         pstrb_d  = write_d ? strb_f(size_d, addr_d[1:0]) : 4'b0000;
      end
      if (state_d == S_SETUP || state_d == S_ACCESS) begin
         for (int unsigned i = 0; i < NSLV; i++) psel_d[i] = (slot_d == SLOT_W'(i));
      end
      penable_d   = (state_d == S_ACCESS);
      hreadyout_d = (state_d == S_IDLE) || (state_d == S_ERR2);
      hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         slot_q    <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         size_q    <= '0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PSTRB     <= '0;
         PWDATA    <= '0;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         slot_q    <= slot_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         size_q    <= size_d;
         PADDR     <= paddr_d;
         PWRITE    <= pwrite_d;
         PSTRB     <= pstrb_d;
         PWDATA    <= pwdata_d;
         HRDATA    <= hrdata_d;
         PSEL      <= psel_d;
         PENABLE   <= penable_d;
         HREADYOUT <= hreadyout_d;
         HRESP     <= hresp_d;
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge (NSLV=4, TIMEOUT=8): vector table through a scoreboard queue,
// plus a back-to-back read/write followed by an asynchronous reset during ACCESS.
module tb_ahb_apb_bridge;

   logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic        PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] HADDR, HWDATA, HRDATA, PWDATA, PRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [15:0] PADDR;
   logic [3:0]  PSEL, PSTRB;

   ahb_apb_bridge #(.NSLV(4), .SLOT_LSB(16), .PADDR_W(16), .TIMEOUT(8)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          lows;
      logic        slverr;
      logic [3:0]  e_psel;
      logic [15:0] e_paddr;
      logic [3:0]  e_pstrb;
      logic        e_err;
      int          e_waits;
      int          e_acc;
      logic [31:0] e_hrdata;
   } vec_t;

   vec_t vecs[9];
   vec_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(logic [31:0] a, logic w, logic [2:0] sz, logic [31:0] wd,
                               logic [31:0] rd, int lows, logic se, logic [3:0] ps,
                               logic [15:0] pa, logic [3:0] st, logic er, int wt, int ac,
                               logic [31:0] hr);
      vec_t v;
      v.addr = a; v.write = w; v.size = sz; v.wdata = wd; v.prdata = rd; v.lows = lows;
      v.slverr = se; v.e_psel = ps; v.e_paddr = pa; v.e_pstrb = st; v.e_err = er;
      v.e_waits = wt; v.e_acc = ac; v.e_hrdata = hr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
      chk({tag, "_hresp"},     32'(HRESP),     32'd0);
      chk({tag, "_hrdata"},    HRDATA,         32'd0);
      chk({tag, "_psel"},      32'(PSEL),      32'd0);
      chk({tag, "_penable"},   32'(PENABLE),   32'd0);
      chk({tag, "_pwrite"},    32'(PWRITE),    32'd0);
      chk({tag, "_paddr"},     32'(PADDR),     32'd0);
      chk({tag, "_pwdata"},    PWDATA,         32'd0);
      chk({tag, "_pstrb"},     32'(PSTRB),     32'd0);
   endtask

   // Address phase; call just after a falling edge.
   task automatic drive_addr(input vec_t v);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.write; HSIZE = v.size;
      sb.push_back(v);
   endtask

   // Data phase of the transfer at the head of the scoreboard; call right after the sampling edge.
   task automatic finish_xfer(input bit b2b, input vec_t nv);
      vec_t v, e;
      int   waits = 0, acc = 0;
      bit   done = 0, seen = 0, stable = 1, err1 = 0;
      logic [3:0]  o_psel = '0, o_pstrb = '0;
      logic [15:0] o_paddr = '0;
      logic        o_pwrite = 1'b0;
      logic [31:0] o_pwdata = '0;
      v = sb[0];
      #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = v.wdata; PRDATA = v.prdata;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge HCLK);
         if (HREADYOUT) begin
            done = 1;
         end else begin
            waits++;
            if (HRESP) err1 = 1;
            if (PSEL != 4'd0) begin
               if (!seen) begin
                  o_psel = PSEL; o_paddr = PADDR; o_pstrb = PSTRB;
                  o_pwrite = PWRITE; o_pwdata = PWDATA; seen = 1;
               end else if ({PSEL, PADDR, PSTRB, PWRITE, PWDATA} !==
                            {o_psel, o_paddr, o_pstrb, o_pwrite, o_pwdata}) begin
                  stable = 0;
               end
            end
            if (PENABLE) begin
               PREADY  = (acc >= v.lows);
               PSLVERR = PREADY & v.slverr;
               acc++;
            end else begin
               PREADY = 1'b0; PSLVERR = 1'b0;
            end
         end
      end
      PREADY = 1'b0; PSLVERR = 1'b0;
      e = sb.pop_front();
      chk("completed", 32'(done), 32'd1);
      chk("waits", 32'(waits), 32'(e.e_waits));
      chk("access_cycles", 32'(acc), 32'(e.e_acc));
      chk("hresp", 32'(HRESP), 32'(e.e_err));
      chk("err1_phase", 32'(err1), 32'(e.e_err));
      chk("psel", 32'(o_psel), 32'(e.e_psel));
      chk("hrdata", HRDATA, e.e_hrdata);
      if (e.e_psel != 4'd0) begin
         chk("paddr", 32'(o_paddr), 32'(e.e_paddr));
         chk("pstrb", 32'(o_pstrb), 32'(e.e_pstrb));
         chk("pwrite", 32'(o_pwrite), 32'(e.write));
         chk("apb_stable", 32'(stable), 32'd1);
         if (e.write) chk("pwdata", o_pwdata, e.wdata);
      end
      if (b2b) begin
         drive_addr(nv);
         @(posedge HCLK);
      end else begin
         @(negedge HCLK);
         chk("idle_ready", 32'(HREADYOUT), 32'd1);
         chk("idle_okay", 32'(HRESP), 32'd0);
      end
   endtask

   initial begin
      vec_t v_rd, v_wr, v_rst, dummy;
      bit   hit;
      //            addr          w  sz    wdata         prdata        lows slv psel   paddr     strb  err wt ac hrdata
      vecs[0] = mk(32'h4002_0010, 1, 3'd2, 32'hA5A5_1234, 32'h0,        0,   0, 4'h4, 16'h0010, 4'hF, 0, 3, 1, 32'h0);
      vecs[1] = mk(32'h4001_0003, 0, 3'd0, 32'h0,         32'hCAFE_F00D, 3,  0, 4'h2, 16'h0003, 4'h0, 0, 5, 4, 32'hCAFE_F00D);
      vecs[2] = mk(32'h4003_0002, 1, 3'd1, 32'h1122_3344, 32'h0,        1,   0, 4'h8, 16'h0002, 4'hC, 0, 4, 2, 32'hCAFE_F00D);
      vecs[3] = mk(32'h4000_0101, 1, 3'd0, 32'hDEAD_BEEF, 32'h0,        0,   1, 4'h1, 16'h0101, 4'h2, 1, 4, 1, 32'hCAFE_F00D);
      vecs[4] = mk(32'h4005_0000, 0, 3'd2, 32'h0,         32'h0,        0,   0, 4'h0, 16'h0000, 4'h0, 1, 1, 0, 32'hCAFE_F00D);
      vecs[5] = mk(32'h4000_0020, 0, 3'd2, 32'h0,         32'h1234_5678, 100, 0, 4'h1, 16'h0020, 4'h0, 1, 10, 8, 32'hCAFE_F00D);
      vecs[6] = mk(32'h4003_0044, 0, 3'd2, 32'h0,         32'h0BAD_C0DE, 0,  1, 4'h8, 16'h0044, 4'h0, 1, 3, 1, 32'hCAFE_F00D);
      vecs[7] = mk(32'h4002_0006, 0, 3'd1, 32'h0,         32'h1357_9BDF, 0,  0, 4'h4, 16'h0006, 4'h0, 0, 2, 1, 32'h1357_9BDF);
      vecs[8] = mk(32'h4001_0013, 1, 3'd0, 32'h0F0F_0F0F, 32'h0,        0,   0, 4'h2, 16'h0013, 4'h8, 0, 3, 1, 32'h1357_9BDF);
      v_rd  = mk(32'h4002_0008, 0, 3'd2, 32'h0, 32'h600D_F00D, 0, 0, 4'h4, 16'h0008, 4'h0, 0, 2, 1, 32'h600D_F00D);
      v_wr  = mk(32'h4001_0004, 1, 3'd2, 32'h8765_4321, 32'h0, 0, 0, 4'h2, 16'h0004, 4'hF, 0, 3, 1, 32'h600D_F00D);
      v_rst = mk(32'h4000_0000, 0, 3'd2, 32'h0, 32'h0, 100, 0, 4'h1, 16'h0000, 4'h0, 0, 0, 0, 32'h0);

      HRESETn = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = '0;
      HREADY = 1'b1; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      #2 HRESETn = 1'b0;
      repeat (2) @(negedge HCLK);
      chk_reset("reset");
      HRESETn = 1'b1;
      @(negedge HCLK);

      foreach (vecs[i]) begin
         drive_addr(vecs[i]);
         @(posedge HCLK);
         finish_xfer(1'b0, vecs[i]);
      end

      // Back-to-back read then write: the write address phase sits in the read's completion cycle.
      drive_addr(v_rd);
      @(posedge HCLK);
      finish_xfer(1'b1, v_wr);
      finish_xfer(1'b0, v_wr);

      // Third transfer stalls in ACCESS; reset must clear everything without a clock edge.
      drive_addr(v_rst);
      @(posedge HCLK);
      #1 HSEL = 1'b0; HTRANS = 2'b00;
      hit = 0;
      for (int c = 0; c < 20 && !hit; c++) begin
         @(negedge HCLK);
         if (PENABLE) hit = 1;
      end
      chk("rst_reached_access", 32'(hit), 32'd1);
      chk("rst_psel_before", 32'(PSEL), 32'h1);
      #1 HRESETn = 1'b0;
      #1 chk_reset("async_reset");
      dummy = sb.pop_front();
      @(negedge HCLK);
      HRESETn = 1'b1;
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
